// File: rtl/cpu_defs.sv
// Shared CPU pipeline definitions: stall FSM encoding and default divider latency.
package cpu_defs;

    typedef enum logic {
        RUN      = 1'b0,
        DIV_WAIT = 1'b1
    } stall_state_t;

    localparam int DIV_CYCLES_DEFAULT = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes precedence over increment.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: divide occupancy, load-use interlock and branch flush,
// plus a saturating count of cycles in which the PC was held.
module stall_ctrl
    import cpu_defs::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  ex_rt,
    input  logic        ex_memread,
    input  logic        ex_div_start,
    input  logic        branch_taken,
    input  logic        clr_stats,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        ifid_clr,
    output logic        idex_clr,
    output logic        exmem_clr,
    output logic        div_busy,
    output logic        div_last,
    output logic [31:0] stall_cycles
);

    localparam int CW = $clog2(DIV_CYCLES) + 1;
    // The start cycle and the final cycle are not counted down, hence the -2.
    localparam logic [CW-1:0] DIV_LOAD = (DIV_CYCLES > 1) ? CW'(DIV_CYCLES - 2) : '0;

    stall_state_t    state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            load_use;

    logic pc_en_dec, ifid_en_dec, idex_en_dec;
    logic ifid_clr_dec, idex_clr_dec, exmem_clr_dec;
    logic div_busy_dec, div_last_dec;

    assign load_use = ex_memread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

    always_comb begin
        pc_en_dec     = 1'b1;
        ifid_en_dec   = 1'b1;
        idex_en_dec   = 1'b1;
        ifid_clr_dec  = 1'b0;
        idex_clr_dec  = 1'b0;
        exmem_clr_dec = 1'b0;
        div_busy_dec  = 1'b0;
        div_last_dec  = 1'b0;
        state_next    = state_reg;
        count_next    = count_reg;

        case (state_reg)
            RUN: begin
                if (ex_div_start) begin
                    if (DIV_CYCLES > 1) begin
                        pc_en_dec     = 1'b0;
                        ifid_en_dec   = 1'b0;
                        idex_en_dec   = 1'b0;
                        exmem_clr_dec = 1'b1;
                        div_busy_dec  = 1'b1;
                        state_next    = DIV_WAIT;
                        count_next    = DIV_LOAD;
                    end else begin
                        div_last_dec  = 1'b1;
                    end
                end else if (load_use) begin
                    pc_en_dec    = 1'b0;
                    ifid_en_dec  = 1'b0;
                    idex_clr_dec = 1'b1;
                end else if (branch_taken) begin
                    ifid_clr_dec = 1'b1;
                end
            end
            DIV_WAIT: begin
                // Hazard inputs are ignored here; ID/EX is held so they re-present in RUN.
                div_busy_dec = 1'b1;
                if (count_reg != '0) begin
                    pc_en_dec     = 1'b0;
                    ifid_en_dec   = 1'b0;
                    idex_en_dec   = 1'b0;
                    exmem_clr_dec = 1'b1;
                    count_next    = count_reg - 1'b1;
                end else begin
                    div_last_dec  = 1'b1;
                    state_next    = RUN;
                end
            end
            default: begin
                state_next = RUN;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= RUN;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // Outputs fall back to the idle RUN values while reset is held.
    assign pc_en     = rst ? pc_en_dec     : 1'b1;
    assign ifid_en   = rst ? ifid_en_dec   : 1'b1;
    assign idex_en   = rst ? idex_en_dec   : 1'b1;
    assign ifid_clr  = rst & ifid_clr_dec;
    assign idex_clr  = rst & idex_clr_dec;
    assign exmem_clr = rst & exmem_clr_dec;
    assign div_busy  = rst & div_busy_dec;
    assign div_last  = rst & div_last_dec;

    sat_counter #(
        .WIDTH (32)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_stats),
        .inc   (~pc_en_dec),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: vector table, directed corner sequences and random stimulus.
module tb_stall_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        ex_memread, ex_div_start, branch_taken, clr_stats;

    logic        pc_en_a, ifid_en_a, idex_en_a, ifid_clr_a, idex_clr_a, exmem_clr_a, div_busy_a, div_last_a;
    logic [31:0] stall_a;
    logic        pc_en_b, ifid_en_b, idex_en_b, ifid_clr_b, idex_clr_b, exmem_clr_b, div_busy_b, div_last_b;
    logic [31:0] stall_b;

    logic [7:0]  o32, o1;
    assign o32 = {pc_en_a, ifid_en_a, idex_en_a, ifid_clr_a, idex_clr_a, exmem_clr_a, div_busy_a, div_last_a};
    assign o1  = {pc_en_b, ifid_en_b, idex_en_b, ifid_clr_b, idex_clr_b, exmem_clr_b, div_busy_b, div_last_b};

    stall_ctrl #(.DIV_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
        .ex_memread(ex_memread), .ex_div_start(ex_div_start), .branch_taken(branch_taken),
        .clr_stats(clr_stats),
        .pc_en(pc_en_a), .ifid_en(ifid_en_a), .idex_en(idex_en_a), .ifid_clr(ifid_clr_a),
        .idex_clr(idex_clr_a), .exmem_clr(exmem_clr_a), .div_busy(div_busy_a),
        .div_last(div_last_a), .stall_cycles(stall_a)
    );

    stall_ctrl #(.DIV_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
        .ex_memread(ex_memread), .ex_div_start(ex_div_start), .branch_taken(branch_taken),
        .clr_stats(clr_stats),
        .pc_en(pc_en_b), .ifid_en(ifid_en_b), .idex_en(idex_en_b), .ifid_clr(ifid_clr_b),
        .idex_clr(idex_clr_b), .exmem_clr(exmem_clr_b), .div_busy(div_busy_b),
        .div_last(div_last_b), .stall_cycles(stall_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output vector layout: {pc_en, ifid_en, idex_en, ifid_clr, idex_clr, exmem_clr, div_busy, div_last}
    localparam logic [7:0] E_IDLE   = 8'b1110_0000;
    localparam logic [7:0] E_LU     = 8'b0010_1000;
    localparam logic [7:0] E_BRANCH = 8'b1111_0000;

    int          checks = 0;
    int          errors = 0;
    int          pos32 = 0, pos1 = 0;
    logic [31:0] cnt32 = 0, cnt1 = 0;
    logic [7:0]  samp32;

    typedef struct {
        string      name;
        logic [4:0] rs, rt, ert;
        logic       mr, br, clr;
        logic [7:0] exp;
    } vec_t;
    vec_t vq[$];

    task automatic add_vec(input string n, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] ert, input logic mr, input logic br,
                           input logic clr, input logic [7:0] exp);
        vec_t v;
        v.name = n; v.rs = rs; v.rt = rt; v.ert = ert;
        v.mr = mr; v.br = br; v.clr = clr; v.exp = exp;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    // Reference: a divide occupies EX for dc cycles numbered 1..dc; cycles before the
    // last hold the front of the pipe, the last one reports the result.
    function automatic logic [7:0] model_eval(input int dc, input int pos, input logic start,
                                              input logic lu, input logic br, output int nxt);
        int cur;
        logic [7:0] o;
        cur = (pos > 0) ? pos : (start ? 1 : 0);
        if (cur > 0 && cur < dc)  o = 8'b0000_0110;
        else if (cur > 0)         o = {6'b111000, (dc > 1), 1'b1};
        else if (lu)              o = E_LU;
        else if (br)              o = E_BRANCH;
        else                      o = E_IDLE;
        nxt = (cur > 0 && cur < dc) ? cur + 1 : 0;
        return o;
    endfunction

    function automatic logic [31:0] cnt_step(input logic [31:0] c, input logic clr, input logic stall);
        if (clr)                            return 32'd0;
        if (stall && c != 32'hFFFF_FFFF)    return c + 32'd1;
        return c;
    endfunction

    // Called just after a rising edge with inputs already driven; ends just after the next edge.
    task automatic run_cycle(input string nm, input logic use_exp, input logic [7:0] exp);
        logic [7:0] e32, e1;
        int n32, n1;
        logic lu;
        #2;
        lu  = ex_memread && (ex_rt != 5'd0) && (ex_rt == id_rs || ex_rt == id_rt);
        e32 = model_eval(32, pos32, ex_div_start, lu, branch_taken, n32);
        e1  = model_eval(1, pos1, ex_div_start, lu, branch_taken, n1);
        if (use_exp) begin
            e32 = exp;
            e1  = exp;
        end
        samp32 = o32;
        chk({nm, "_out32"}, {24'd0, o32}, {24'd0, e32});
        chk({nm, "_out1"},  {24'd0, o1},  {24'd0, e1});
        pos32 = n32;
        pos1  = n1;
        cnt32 = cnt_step(cnt32, clr_stats, !e32[7]);
        cnt1  = cnt_step(cnt1,  clr_stats, !e1[7]);
        @(posedge clk);
        #1;
        chk({nm, "_stall32"}, stall_a, cnt32);
        chk({nm, "_stall1"},  stall_b, cnt1);
        $display("cyc %-12s out32=%b out1=%b stall32=%h stall1=%h", nm, samp32, o1, stall_a, stall_b);
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; ex_rt = 0;
        ex_memread = 0; ex_div_start = 0; branch_taken = 0; clr_stats = 0;
    endtask

    task automatic rand_inputs(input logic allow_clr);
        id_rs        = 5'($urandom_range(0, 3));
        id_rt        = 5'($urandom_range(0, 3));
        ex_rt        = 5'($urandom_range(0, 3));
        ex_memread   = 1'($urandom_range(0, 1));
        ex_div_start = ($urandom_range(0, 19) == 0);
        branch_taken = ($urandom_range(0, 3) == 0);
        clr_stats    = allow_clr && ($urandom_range(0, 31) == 0);
    endtask

    initial begin
        int nst, lastk;

        // Reset with hazards present: outputs must stay at idle values.
        rst = 1'b0;
        idle_inputs();
        ex_memread = 1; ex_rt = 5; id_rs = 5; ex_div_start = 1;
        @(posedge clk);
        #1;
        chk("rst_out32",   {24'd0, o32}, {24'd0, E_IDLE});
        chk("rst_out1",    {24'd0, o1},  {24'd0, E_IDLE});
        chk("rst_stall32", stall_a, 32'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        rst = 1'b1;

        add_vec("idle",       0, 0, 0,  0, 0, 0, E_IDLE);
        add_vec("lu_rs",      5, 3, 5,  1, 0, 0, E_LU);
        add_vec("lu_rt",      1, 7, 7,  1, 0, 0, E_LU);
        add_vec("zero_reg",   0, 0, 0,  1, 0, 0, E_IDLE);
        add_vec("no_load",    9, 2, 9,  0, 0, 0, E_IDLE);
        add_vec("lu_miss",    5, 6, 4,  1, 0, 0, E_IDLE);
        add_vec("branch",     1, 2, 3,  0, 1, 0, E_BRANCH);
        add_vec("branch_lu",  8, 2, 8,  1, 1, 0, E_LU);
        add_vec("branch_zr",  0, 4, 0,  1, 1, 0, E_BRANCH);
        add_vec("lu_clr",     3, 3, 3,  1, 0, 1, E_LU);
        add_vec("lu_rs_31",  31, 0, 31, 1, 0, 0, E_LU);
        for (int i = 0; i < vq.size(); i++) begin
            id_rs = vq[i].rs; id_rt = vq[i].rt; ex_rt = vq[i].ert;
            ex_memread = vq[i].mr; branch_taken = vq[i].br; clr_stats = vq[i].clr;
            ex_div_start = 0;
            run_cycle(vq[i].name, 1'b1, vq[i].exp);
        end
        idle_inputs();

        // Full divide from a cleared counter, with noise on the hazard inputs while waiting.
        clr_stats = 1;
        run_cycle("clr", 1'b0, 8'd0);
        clr_stats = 0;
        ex_div_start = 1;
        run_cycle("div_k1", 1'b0, 8'd0);
        nst   = (samp32[7] == 1'b0) ? 1 : 0;
        lastk = samp32[0] ? 1 : 0;
        for (int k = 2; k <= 32; k++) begin
            rand_inputs(1'b0);
            run_cycle("div_wait", 1'b0, 8'd0);
            if (samp32[7] == 1'b0) nst++;
            if (samp32[0]) lastk = k;
        end
        idle_inputs();
        chk("div_stall_len", nst, 31);
        chk("div_last_cyc",  lastk, 32);
        chk("div_stall_cnt", stall_a, 32'd31);
        run_cycle("div_after", 1'b1, E_IDLE);

        // Branch colliding with a load-use: the flush follows one cycle later.
        ex_memread = 1; ex_rt = 5; id_rs = 5; branch_taken = 1;
        run_cycle("collide", 1'b1, E_LU);
        ex_memread = 0;
        run_cycle("collide_nx", 1'b1, E_BRANCH);
        idle_inputs();

        // Reset asserted at the tenth wait cycle of a divide.
        ex_div_start = 1;
        run_cycle("div2_k1", 1'b0, 8'd0);
        ex_div_start = 0;
        for (int k = 1; k <= 10; k++) run_cycle("div2_wait", 1'b0, 8'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_out",   {24'd0, o32}, {24'd0, E_IDLE});
        chk("mid_rst_stall", stall_a, 32'd0);
        pos32 = 0; pos1 = 0; cnt32 = 0; cnt1 = 0;
        @(posedge clk);
        #1;
        chk("mid_rst_hold",  {24'd0, o32}, {24'd0, E_IDLE});
        rst = 1'b1;
        for (int k = 0; k < 3; k++) run_cycle("post_rst", 1'b1, E_IDLE);
        chk("post_rst_cnt", stall_a, 32'd0);

        // Saturation of the stall counter, then clear during a stall.
        dut.u_stall_cnt.count_reg = 32'hFFFF_FFFD;
        cnt32 = 32'hFFFF_FFFD;
        ex_memread = 1; ex_rt = 5; id_rs = 5;
        for (int k = 0; k < 5; k++) run_cycle("sat", 1'b1, E_LU);
        chk("sat_hold", stall_a, 32'hFFFF_FFFF);
        clr_stats = 1;
        run_cycle("sat_clr", 1'b1, E_LU);
        chk("sat_clr_val", stall_a, 32'd0);
        idle_inputs();

        // Random traffic against the reference model.
        for (int n = 0; n < 500; n++) begin
            rand_inputs(1'b1);
            run_cycle("rand", 1'b0, 8'd0);
        end
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
